// File: rtl/array_multiplier_4x4.sv
// Unsigned WIDTH x WIDTH carry-save array multiplier with a ripple-carry final row
// and one registered output stage (fixed one-cycle latency).
module array_multiplier_4x4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               in_valid,
  output logic [2*WIDTH-1:0] z,
  output logic               out_valid
);

  // Row-major flattening: element [i*WIDTH+j] is row i, column j (weight i+j).
  logic [WIDTH*WIDTH-1:0] pp;
  logic [WIDTH*WIDTH-1:0] row_sum;
  logic [WIDTH*WIDTH-1:0] row_carry;
  logic [WIDTH-2:0]       ripple_carry;
  logic [2*WIDTH-1:0]     prod_p0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_pp_col
      assign pp[i*WIDTH+j] = x[j] & y[i];
    end
  end

  // Row 0 is the first partial-product row with no carries yet.
  assign row_sum[WIDTH-1:0]   = pp[WIDTH-1:0];
  assign row_carry[WIDTH-1:0] = '0;

  // Each cell adds pp[i][j], the previous row's sum one column up, and the previous row's carry.
  for (genvar i = 1; i < WIDTH; i++) begin : g_row
    for (genvar j = 0; j < WIDTH; j++) begin : g_cell
      if (j == WIDTH-1) begin : g_edge_ha
        assign row_sum[i*WIDTH+j]   = pp[i*WIDTH+j] ^ row_carry[(i-1)*WIDTH+j];
        assign row_carry[i*WIDTH+j] = pp[i*WIDTH+j] & row_carry[(i-1)*WIDTH+j];
      end else if (i == 1) begin : g_first_ha
        assign row_sum[i*WIDTH+j]   = pp[i*WIDTH+j] ^ row_sum[(i-1)*WIDTH+j+1];
        assign row_carry[i*WIDTH+j] = pp[i*WIDTH+j] & row_sum[(i-1)*WIDTH+j+1];
      end else begin : g_fa
        logic a, b, c;
        assign a = pp[i*WIDTH+j];
        assign b = row_sum[(i-1)*WIDTH+j+1];
        assign c = row_carry[(i-1)*WIDTH+j];
        assign row_sum[i*WIDTH+j]   = a ^ b ^ c;
        assign row_carry[i*WIDTH+j] = (a & b) | (a & c) | (b & c);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_low_bits
    assign prod_p0[i] = row_sum[i*WIDTH];
  end

  // Final ripple row resolves the last sum/carry vectors into the upper WIDTH bits.
  for (genvar k = 0; k < WIDTH-1; k++) begin : g_ripple
    logic a, b;
    assign a = row_sum[(WIDTH-1)*WIDTH+k+1];
    assign b = row_carry[(WIDTH-1)*WIDTH+k];
    if (k == 0) begin : g_ha
      assign prod_p0[WIDTH+k]  = a ^ b;
      assign ripple_carry[k]   = a & b;
    end else begin : g_fa
      logic c;
      assign c = ripple_carry[k-1];
      assign prod_p0[WIDTH+k]  = a ^ b ^ c;
      assign ripple_carry[k]   = (a & b) | (a & c) | (b & c);
    end
  end

  // The top column cannot carry out because the product always fits in 2*WIDTH bits.
  assign prod_p0[2*WIDTH-1] = row_carry[WIDTH*WIDTH-1] ^ ripple_carry[WIDTH-2];

  // Stage p0 -> output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z         <= '0;
      out_valid <= 1'b0;
    end else begin
      z         <= prod_p0;
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_array_multiplier_4x4.sv
// Randomized self-checking bench for array_multiplier_4x4 at WIDTH=4 (exhaustive) and WIDTH=6 (sampled).
module tb_array_multiplier_4x4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic [5:0]  x6 = '0, y6 = '0;
  logic        iv4 = 1'b0, iv6 = 1'b0;
  logic [7:0]  z4;
  logic [11:0] z6;
  logic        ov4, ov6;
  int          n_cmp = 0;
  int          n_bad = 0;

  array_multiplier_4x4 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .in_valid(iv4), .z(z4), .out_valid(ov4)
  );

  array_multiplier_4x4 #(.WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .x(x6), .y(y6), .in_valid(iv6), .z(z6), .out_valid(ov6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step4(input int a, input int b, input logic v, input string tag);
    x4 = 4'(a); y4 = 4'(b); iv4 = v;
    @(posedge clk); #1;
    chk(tag, 32'(z4), 32'(a * b));
    chk({tag, "_vld"}, 32'(ov4), 32'(v));
  endtask

  task automatic step6(input int a, input int b, input logic v, input string tag);
    x6 = 6'(a); y6 = 6'(b); iv6 = v;
    @(posedge clk); #1;
    chk(tag, 32'(z6), 32'(a * b));
    chk({tag, "_vld"}, 32'(ov6), 32'(v));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  int da[8] = '{1, 7, 8, 15, 3, 15, 6, 4};
  int db[8] = '{0, 5, 9, 15, 2, 1, 10, 8};

  initial begin
    int a, b, prev;
    logic v;

    // Reset held with all-ones operands and a running clock.
    x4 = 4'hF; y4 = 4'hF; iv4 = 1'b1;
    x6 = 6'h3F; y6 = 6'h3F; iv6 = 1'b1;
    #1;
    chk("rst_async_z", 32'(z4), 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_z4", 32'(z4), 32'h0);
      chk("rst_ov4", 32'(ov4), 32'h0);
      chk("rst_z6", 32'(z6), 32'h0);
      chk("rst_ov6", 32'(ov6), 32'h0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) step4(da[i], db[i], 1'b1, $sformatf("dir_%0dx%0d", da[i], db[i]));

    step4(3, 5, 1'b0, "inval_3x5");

    for (int k = 0; k < 16; k++) begin
      step4(0, k, 1'b1, "zero_x");
      step4(1, k, 1'b1, "ident_x1");
      step4(k, 1, 1'b1, "ident_y1");
    end

    // Exhaustive sweep, with in_valid randomized.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        v = 1'($urandom_range(0, 1));
        step4(i, j, v, "exh");
      end

    // Streaming: operands change between edges must not disturb the registered product.
    for (int n = 0; n < 150; n++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      v = 1'($urandom_range(0, 1));
      step4(a, b, v, "stream");
      prev = a * b;
      x4 = ~x4; y4 = 4'($urandom_range(0, 15)); iv4 = ~iv4;
      #2;
      chk("stream_hold_z", 32'(z4), 32'(prev));
      chk("stream_hold_vld", 32'(ov4), 32'(v));
    end

    // Mid-stream asynchronous reset clears without a clock edge.
    step4(15, 15, 1'b1, "pre_rst");
    step6(63, 63, 1'b1, "pre_rst6");
    rst_n = 1'b0;
    #1;
    chk("midrst_z4", 32'(z4), 32'h0);
    chk("midrst_ov4", 32'(ov4), 32'h0);
    chk("midrst_z6", 32'(z6), 32'h0);
    #1;
    rst_n = 1'b1;
    step4(13, 11, 1'b1, "post_rst");

    // WIDTH=6 corner cases then random sample.
    step6(63, 63, 1'b1, "w6_max");
    step6(0, 63, 1'b1, "w6_zero");
    step6(1, 42, 1'b0, "w6_ident");
    for (int n = 0; n < 1000; n++) begin
      a = int'($urandom_range(0, 63));
      b = int'($urandom_range(0, 63));
      v = 1'($urandom_range(0, 1));
      step6(a, b, v, "w6_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
